// File: rtl/inst_encoder_loader.sv
// Instruction encoder/loader: turns mnemonic-level commands into 32-bit MIPS words
// and writes them one per two cycles into an instruction memory starting at BASE_ADDR.
module inst_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_mnem,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_shamt,
    input  logic [5:0]  cmd_funct,
    input  logic [15:0] cmd_imm,
    input  logic [25:0] cmd_target,
    input  logic        clear,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        full,
    output logic        err,
    output logic [15:0] count
);

    localparam logic [15:0] DEPTH_W = DEPTH[15:0];

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    state_t      state;
    logic [32:0] enc;
    logic [15:0] count_inc;

    // Returns {legal, word}; legal is 0 for unassigned selectors.
    function automatic logic [32:0] encode(
        input logic [4:0]  mnem,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [5:0]  op;
        logic [32:0] res;
        op  = 6'b000000;
        res = 33'd0;
        case (mnem)
            5'd2:  op = 6'b100000;
            5'd3:  op = 6'b100011;
            5'd4:  op = 6'b101000;
            5'd5:  op = 6'b101011;
            5'd6:  op = 6'b000100;
            5'd7:  op = 6'b000101;
            5'd8:  op = 6'b000111;
            5'd9:  op = 6'b001000;
            5'd10: op = 6'b001001;
            5'd11: op = 6'b000010;
            5'd12: op = 6'b000011;
            5'd13: op = 6'b001100;
            5'd14: op = 6'b001101;
            5'd15: op = 6'b001111;
            5'd16: op = 6'b001110;
            default: op = 6'b000000;
        endcase
        case (mnem)
            5'd0:  res = {1'b1, 6'b000000, rs, rt, rd, shamt, funct};
            5'd1:  res = {1'b1, 6'b011100, rs, rt, rd, 5'b00000, 6'b000010};
            5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd13, 5'd14, 5'd16:
                   res = {1'b1, op, rs, rt, imm};
            5'd8:  res = {1'b1, op, rs, 5'b00000, imm};
            5'd15: res = {1'b1, op, 5'b00000, rt, imm};
            5'd11, 5'd12:
                   res = {1'b1, op, target};
            default: res = 33'd0;
        endcase
        return res;
    endfunction

    assign enc       = encode(cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_shamt,
                              cmd_funct, cmd_imm, cmd_target);
    assign count_inc = count + 16'd1;
    assign cmd_ready = (state == IDLE);
    assign full      = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        count <= 16'd0;
                    end else if (cmd_valid) begin
                        if (enc[32]) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE_ADDR + {14'd0, count, 2'b00};
                            imem_wdata <= enc[31:0];
                            state      <= WRITE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                // The write itself happens during this state; clear only affects the bookkeeping.
                WRITE: begin
                    if (clear) begin
                        count <= 16'd0;
                        state <= IDLE;
                    end else begin
                        count <= count_inc;
                        state <= (count_inc == DEPTH_W) ? FULL : IDLE;
                    end
                end
                FULL: begin
                    if (clear) begin
                        count <= 16'd0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader (DEPTH=2 so full/clear paths are reached quickly).
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_mnem = '0;
    logic [4:0]  cmd_rs = '0;
    logic [4:0]  cmd_rt = '0;
    logic [4:0]  cmd_rd = '0;
    logic [4:0]  cmd_shamt = '0;
    logic [5:0]  cmd_funct = '0;
    logic [15:0] cmd_imm = '0;
    logic [25:0] cmd_target = '0;
    logic        clear = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        full;
    logic        err;
    logic [15:0] count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    inst_encoder_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mnem(cmd_mnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .clear(clear),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .full(full), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] mnem, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                        input logic [15:0] imm, input logic [25:0] target,
                        input bit push, input logic [31:0] ea, input logic [31:0] ed);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: cmd_ready got 0 expected 1");
        end
        cmd_mnem = mnem; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_shamt = shamt; cmd_funct = funct; cmd_imm = imm; cmd_target = target;
        cmd_valid = 1'b1;
        if (push) exp_q.push_back('{ea, ed});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", imem_addr, e.addr);
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // lw $8, 0x10($29)
        send(5'd3, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b1, 32'h0, 32'h8FA8_0010);
        chk("lw_we", {31'd0, imem_we}, 32'd1);
        tick();
        chk("lw_count", {16'd0, count}, 32'd1);
        chk("lw_we_low", {31'd0, imem_we}, 32'd0);
        chk("hold_addr", imem_addr, 32'h0);
        chk("hold_wdata", imem_wdata, 32'h8FA8_0010);
        do_clear();
        chk("clr_count", {16'd0, count}, 32'd0);

        // add $10,$8,$9 then jal 0x100, filling DEPTH=2
        send(5'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'b100000, 16'd0, 26'd0, 1'b1, 32'h0, 32'h0109_5020);
        send(5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000100, 1'b1, 32'h4, 32'h0C00_0100);
        tick();
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_count", {16'd0, count}, 32'd2);
        cmd_mnem = 5'd3; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_imm = 16'h0004;
        cmd_valid = 1'b1;
        repeat (3) tick();
        cmd_valid = 1'b0;
        chk("full_ignore_count", {16'd0, count}, 32'd2);
        chk("full_stays", {31'd0, full}, 32'd1);
        do_clear();
        chk("full_clr_count", {16'd0, count}, 32'd0);
        chk("full_clr_full", {31'd0, full}, 32'd0);
        chk("full_clr_ready", {31'd0, cmd_ready}, 32'd1);

        // lui (rs forced 0) then bgtz (rt forced 0)
        send(5'd15, 5'd5, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b1, 32'h0, 32'h3C01_1234);
        send(5'd8, 5'd3, 5'd7, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b1, 32'h4, 32'h1C60_FFFE);
        tick();
        do_clear();

        // mul ignores shamt/funct; then an illegal selector; then sw lands at the next address
        send(5'd1, 5'd1, 5'd2, 5'd3, 5'd31, 6'h3F, 16'd0, 26'd0, 1'b1, 32'h0, 32'h7022_1802);
        send(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h5555, 26'd0, 1'b0, 32'h0, 32'h0);
        chk("illegal_err", {31'd0, err}, 32'd1);
        chk("illegal_we", {31'd0, imem_we}, 32'd0);
        chk("illegal_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk("illegal_err_drop", {31'd0, err}, 32'd0);
        chk("illegal_count", {16'd0, count}, 32'd1);
        send(5'd5, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b1, 32'h4, 32'hAC43_0008);
        tick();
        chk("sw_full", {31'd0, full}, 32'd1);
        do_clear();

        // reset mid-write aborts asynchronously
        send(5'd3, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 32'h0, 32'h0);
        chk("abort_we_before", {31'd0, imem_we}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_we_async", {31'd0, imem_we}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_count", {16'd0, count}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        send(5'd9, 5'd0, 5'd4, 5'd0, 5'd0, 6'd0, 16'h7FFF, 26'd0, 1'b1, 32'h0, 32'h2004_7FFF);
        tick();
        chk("addi_count", {16'd0, count}, 32'd1);

        // clear during WRITE: write completes, count returns to 0
        send(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b1, 32'h4, 32'h3422_00FF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("wclr_count", {16'd0, count}, 32'd0);
        chk("wclr_ready", {31'd0, cmd_ready}, 32'd1);
        send(5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1, 32'h0, 32'h3800_FFFF);
        tick();
        chk("xori_count", {16'd0, count}, 32'd1);

        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_encoder_loader.md
INST_ENCODER_LOADER -- requirements
Module: inst_encoder_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, first byte address written.
REQ-002 SHALL have parameter DEPTH, default 256, maximum words written before full.
REQ-003 SHALL have ports, in order: clk input 1 (rising-edge clock); rst input 1 (asynchronous active-high reset).
REQ-004 SHALL have port cmd_valid input 1: command present.
REQ-005 SHALL have port cmd_ready output 1: command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_mnem input 5: instruction selector (encoding in REQ-012).
REQ-007 SHALL have ports cmd_rs, cmd_rt and cmd_rd, inputs 5 each: register fields.
REQ-008 SHALL have ports cmd_shamt input 5, cmd_funct input 6 (R-type only), cmd_imm input 16, and cmd_target input 26 (j/jal).
REQ-009 SHALL have port clear input 1: synchronous restart of address and count.
REQ-010 SHALL have ports imem_we output 1, imem_addr output 32 and imem_wdata output 32: instruction memory write port.
REQ-011 SHALL have ports full output 1, err output 1 (one-cycle illegal-command pulse) and count output 16 (words written).

Function
REQ-012 SHALL map cmd_mnem as follows: 0 R-type op 000000; 1 mul op 011100; 2 lb 100000; 3 lw 100011; 4 sb 101000; 5 sw 101011; 6 beq 000100; 7 bne 000101; 8 bgtz 000111; 9 addi 001000; 10 addiu 001001; 11 j 000010; 12 jal 000011; 13 andi 001100; 14 ori 001101; 15 lui 001111; 16 xori 001110; 17-31 illegal.
REQ-013 SHALL encode R-type as {op, rs, rt, rd, shamt, funct}.
REQ-014 SHALL encode mul as {011100, rs, rt, rd, 00000, 000010}, ignoring cmd_shamt and cmd_funct.
REQ-015 SHALL encode I-format (mnem 2-10, 13-16) as {op, rs, rt, imm}, with rs forced to 0 for lui and rt forced to 0 for bgtz.
REQ-016 SHALL encode j and jal as {op, target}.
REQ-017 SHALL implement FSM states IDLE, WRITE and FULL.
REQ-018 SHALL drive cmd_ready=1 only in IDLE.
REQ-019 On a legal handshake in IDLE, SHALL register the encoded word and go to WRITE.
REQ-020 In WRITE, SHALL assert imem_we=1 for exactly one cycle, with imem_addr=BASE_ADDR+4*count and imem_wdata=registered word.
REQ-021 On the clock edge ending WRITE, SHALL increment count and go to FULL if count reaches DEPTH, otherwise to IDLE.
REQ-022 Throughput SHALL be one instruction per 2 cycles; write latency SHALL be 1 cycle after the accept edge.
REQ-023 On an illegal handshake in IDLE, SHALL pulse err=1 the next cycle, issue no write, leave count unchanged and remain in IDLE.
REQ-024 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.
REQ-025 In FULL, SHALL hold full=1 and cmd_ready=0 and ignore cmd_valid.
REQ-026 clear=1 in any state SHALL set count=0 and state=IDLE, and suppress a same-cycle handshake.
REQ-027 If clear is asserted during WRITE, the pending write SHALL still complete that cycle, but count SHALL become 0, not count+1.
REQ-028 full SHALL equal (state==FULL).
REQ-029 count arithmetic SHALL be 16-bit unsigned, and DEPTH SHALL be at most 65535.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, count=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, err=0 and full=0, with cmd_ready=1 after deassertion.
REQ-031 rst asserted during WRITE SHALL abort the write (imem_we drops asynchronously) and no count increment SHALL occur.

Verification
REQ-032 lw: mnem 3, rs 29, rt 8, imm 16'h0010 accepted -> next cycle imem_we=1, addr 0x0, wdata 32'h8FA8_0010, then count=1.
REQ-033 R-type add followed by jal target 26'h0000100 -> wdata 32'h0109_5020 at 0x0 (rs 8, rt 9, rd 10, funct 100000), then 32'h0C00_0100 at 0x4.
REQ-034 lui (rs input 5, rt 1, imm 16'h1234) then bgtz (rs 3, rt 7, imm 16'hFFFE) -> wdata 32'h3C01_1234, then 32'h1C60_FFFE.
REQ-035 mnem 20 -> err pulses for 1 cycle, imem_we stays 0, count unchanged, and the next legal command writes to the unchanged address.
REQ-036 With DEPTH=2, three back-to-back commands -> two writes, full=1, cmd_ready=0 and the third command is not accepted; clear returns the block to IDLE with count=0.
REQ-037 rst pulsed mid-WRITE -> imem_we drops without waiting for a clock edge, count=0, and the next write targets BASE_ADDR.
